// File: rtl/dispatch_queue.sv
// In-order multi-issue dispatch queue: circular buffer of decoded packets released under per-FU RS credits and ROB credits.
// Latency: enqueue at edge N is visible on disp_* in cycle N+1; dispatch outputs are combinational from registered state.
// Backpressure: enq_ready only when a full ENQ_W group fits in registered occupancy; first blocked slot blocks all younger slots.
module dispatch_queue #(
    parameter  int DEPTH    = 8,
    parameter  int ENQ_W    = 2,
    parameter  int DEQ_W    = 2,
    parameter  int PKT_W    = 128,
    parameter  int NUM_FU   = 4,
    parameter  int FU_IDX_W = 2,
    localparam int CNT_W    = $clog2(DEQ_W + 1),
    localparam int OCC_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [ENQ_W-1:0]          enq_valid,
    input  logic [ENQ_W*PKT_W-1:0]    enq_pkt,
    input  logic [ENQ_W*FU_IDX_W-1:0] enq_fu,
    output logic                      enq_ready,
    input  logic [NUM_FU*CNT_W-1:0]   rs_free,
    input  logic [CNT_W-1:0]          rob_free,
    output logic [DEQ_W-1:0]          disp_valid,
    output logic [DEQ_W*PKT_W-1:0]    disp_pkt,
    output logic [DEQ_W*FU_IDX_W-1:0] disp_fu,
    output logic [NUM_FU-1:0]         rs_load,
    output logic                      stall,
    output logic [OCC_W-1:0]          occupancy
);

    logic [PKT_W-1:0]    mem_pkt [DEPTH];
    logic [FU_IDX_W-1:0] mem_fu  [DEPTH];

    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    rs_cred [NUM_FU];
    logic [CNT_W-1:0]    fu_used [NUM_FU];
    logic [OCC_W-1:0]    n_deq, n_enq, free_slots;
    logic                enq_fire;
    logic                blocked;
    logic [PTR_W-1:0]    rd_idx;
    logic [FU_IDX_W-1:0] rd_fu;

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            rs_cred[f] = rs_free[f*CNT_W +: CNT_W];
        end
    end

    // Walk candidate slots oldest-first; the first slot that fails any credit check stops selection.
    always_comb begin
        disp_valid = '0;
        disp_pkt   = '0;
        disp_fu    = '0;
        rs_load    = '0;
        n_deq      = '0;
        blocked    = flush;
        rd_idx     = '0;
        rd_fu      = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_used[f] = '0;
        end
        for (int k = 0; k < DEQ_W; k++) begin
            rd_idx = head + PTR_W'(k);
            rd_fu  = mem_fu[rd_idx];
            if (!blocked && (OCC_W'(k) < occupancy) && (CNT_W'(k) < rob_free)
                && (fu_used[rd_fu] < rs_cred[rd_fu])) begin
                disp_valid[k]                   = 1'b1;
                disp_pkt[k*PKT_W +: PKT_W]      = mem_pkt[rd_idx];
                disp_fu[k*FU_IDX_W +: FU_IDX_W] = rd_fu;
                rs_load[rd_fu]                  = 1'b1;
                fu_used[rd_fu]                  = fu_used[rd_fu] + CNT_W'(1);
                n_deq                           = n_deq + OCC_W'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    assign stall      = (occupancy != '0) && (disp_valid == '0) && !flush;
    assign free_slots = OCC_W'(DEPTH) - occupancy;
    assign enq_ready  = (free_slots >= OCC_W'(ENQ_W)) && !flush;
    assign enq_fire   = enq_ready && enq_valid[0];

    always_comb begin
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            if (enq_fire && enq_valid[i]) begin
                n_enq = n_enq + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(n_deq);
            tail      <= tail + PTR_W'(n_enq);
            occupancy <= occupancy + n_enq - n_deq;
        end
    end

    // Payload storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++) begin
            if (enq_fire && enq_valid[i]) begin
                mem_pkt[tail + PTR_W'(i)] <= enq_pkt[i*PKT_W +: PKT_W];
                mem_fu[tail + PTR_W'(i)]  <= enq_fu[i*FU_IDX_W +: FU_IDX_W];
            end
        end
    end

`ifndef SYNTHESIS
    a_enq_contig: assert property (@(posedge clk) disable iff (!reset_n)
        (enq_valid & (enq_valid + ENQ_W'(1))) == '0);
    a_enq_when_ready: assert property (@(posedge clk) disable iff (!reset_n)
        (enq_valid[0] && !flush) |-> enq_ready);
    a_enq_fu_range: assert property (@(posedge clk) disable iff (!reset_n)
        (enq_valid[0] -> (int'(enq_fu[FU_IDX_W-1:0]) < NUM_FU)) &&
        (enq_valid[ENQ_W-1] -> (int'(enq_fu[(ENQ_W-1)*FU_IDX_W +: FU_IDX_W]) < NUM_FU)));
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed and randomized checks of dispatch_queue against a packet-queue reference model.
module tb_dispatch_queue;

    localparam logic [1:0] LSU = 2'd0, MULT = 2'd1, BTU = 2'd2, ALU = 2'd3;

    logic         clk, reset_n, flush;
    logic [1:0]   enq_valid;
    logic [255:0] enq_pkt;
    logic [3:0]   enq_fu;
    logic         enq_ready;
    logic [7:0]   rs_free;
    logic [1:0]   rob_free;
    logic [1:0]   disp_valid;
    logic [255:0] disp_pkt;
    logic [3:0]   disp_fu;
    logic [3:0]   rs_load;
    logic         stall;
    logic [3:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] q_pkt[$];
    logic [1:0]   q_fu[$];

    dispatch_queue dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .enq_valid(enq_valid), .enq_pkt(enq_pkt), .enq_fu(enq_fu), .enq_ready(enq_ready),
        .rs_free(rs_free), .rob_free(rob_free),
        .disp_valid(disp_valid), .disp_pkt(disp_pkt), .disp_fu(disp_fu),
        .rs_load(rs_load), .stall(stall), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rfu();
        return 2'($urandom_range(3));
    endfunction

    function automatic logic [7:0] rrs();
        logic [7:0] v;
        for (int f = 0; f < 4; f++) v[f*2 +: 2] = 2'($urandom_range(2));
        return v;
    endfunction

    // One cycle: drive at negedge, check against the model, advance the model at posedge.
    task automatic step(input bit fl, input int ne_req, input logic [1:0] f0, input logic [1:0] f1,
                        input logic [7:0] rsf, input logic [1:0] robf, output int accepted);
        int occ, ne, exp_n;
        int used[4];
        bit rdy;
        logic [3:0] exp_load;
        logic [1:0] exp_dv, fu_k;
        logic [127:0] p0, p1;
        occ = q_pkt.size();
        rdy = (8 - occ >= 2) && !fl;
        ne  = (rdy || fl) ? ne_req : 0;
        p0 = {$urandom, $urandom, $urandom, $urandom};
        p1 = {$urandom, $urandom, $urandom, $urandom};
        flush     = fl;
        enq_valid = (ne == 2) ? 2'b11 : (ne == 1) ? 2'b01 : 2'b00;
        enq_pkt   = {p1, p0};
        enq_fu    = {f1, f0};
        rs_free   = rsf;
        rob_free  = robf;
        foreach (used[f]) used[f] = 0;
        exp_n = 0;
        exp_load = '0;
        for (int k = 0; k < 2; k++) begin
            if (fl || k >= occ || k >= int'(robf)) break;
            fu_k = q_fu[k];
            if (used[fu_k] >= int'(rsf[fu_k*2 +: 2])) break;
            used[fu_k]++;
            exp_load[fu_k] = 1'b1;
            exp_n++;
        end
        exp_dv = (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00;
        #1;
        chk("occupancy", occupancy, occ);
        chk("enq_ready", enq_ready, rdy);
        chk("disp_valid", disp_valid, exp_dv);
        chk("rs_load", rs_load, exp_load);
        chk("stall", stall, (occ != 0) && (exp_n == 0) && !fl);
        for (int k = 0; k < exp_n; k++) begin
            chk("disp_pkt", disp_pkt[k*128 +: 128], q_pkt[k]);
            chk("disp_fu", disp_fu[k*2 +: 2], q_fu[k]);
        end
        @(posedge clk);
        accepted = 0;
        if (fl) begin
            q_pkt.delete();
            q_fu.delete();
        end else begin
            repeat (exp_n) begin
                void'(q_pkt.pop_front());
                void'(q_fu.pop_front());
            end
            if (ne >= 1) begin q_pkt.push_back(p0); q_fu.push_back(f0); accepted++; end
            if (ne == 2) begin q_pkt.push_back(p1); q_fu.push_back(f1); accepted++; end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int a;
        for (int i = 0; i < 20 && q_pkt.size() != 0; i++) step(0, 0, LSU, LSU, 8'hAA, 2, a);
        chk("drain_empty", occupancy, 0);
    endtask

    initial begin
        int a, sent;
        reset_n = 1'b1; flush = 1'b0; enq_valid = '0; enq_pkt = '0; enq_fu = '0;
        rs_free = 8'hAA; rob_free = 2'd2;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_rs_load", rs_load, 0);
        chk("rst_stall", stall, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic flow: ALU then MULT, both leave on the next cycle.
        step(0, 2, ALU, MULT, 8'hAA, 2, a);
        chk("basic_occ_before", occupancy, 2);
        step(0, 0, LSU, LSU, 8'hAA, 2, a);
        chk("basic_occ_after", occupancy, 0);

        // Per-FU credit: ALU,ALU with no credit, then one ALU credit per cycle.
        step(0, 2, ALU, ALU, 8'h00, 2, a);
        step(0, 0, LSU, LSU, 8'h00, 2, a);
        chk("credit_stall_occ", occupancy, 2);
        step(0, 0, LSU, LSU, 8'h40, 2, a);
        step(0, 0, LSU, LSU, 8'h40, 2, a);
        chk("credit_drained", occupancy, 0);

        // In-order blocking behind MULT, then ROB limit of one.
        step(0, 2, MULT, ALU, 8'h00, 2, a);
        step(0, 0, LSU, LSU, 8'h80, 2, a);
        step(0, 0, LSU, LSU, 8'hAA, 1, a);
        drain();

        // Fill to full, then stream 20 packets across the pointer wrap.
        for (int i = 0; i < 4; i++) step(0, 2, rfu(), rfu(), 8'h00, 2, a);
        chk("full_occ", occupancy, 8);
        chk("full_enq_ready", enq_ready, 0);
        step(0, 2, rfu(), rfu(), 8'hAA, 2, a);
        chk("full_no_enq_while_draining", occupancy, 6);
        sent = 0;
        for (int i = 0; i < 100 && sent < 20; i++) begin
            step(0, (sent < 19) ? 2 : 1, rfu(), rfu(), 8'hAA, 2, a);
            sent += a;
        end
        chk("stream_sent", sent, 20);
        drain();

        // Simultaneous enqueue and dispatch at occupancy 4.
        step(0, 2, LSU, BTU, 8'h00, 2, a);
        step(0, 2, MULT, ALU, 8'h00, 2, a);
        step(0, 2, ALU, LSU, 8'hAA, 2, a);
        chk("simul_occ", occupancy, 4);
        drain();

        // Flush at occupancy 5 with a concurrent enqueue.
        step(0, 2, ALU, ALU, 8'h00, 2, a);
        step(0, 2, MULT, BTU, 8'h00, 2, a);
        step(0, 1, LSU, LSU, 8'h00, 2, a);
        chk("flush_pre_occ", occupancy, 5);
        step(1, 2, ALU, ALU, 8'hAA, 2, a);
        chk("flush_post_occ", occupancy, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(15) == 0), $urandom_range(2), rfu(), rfu(), rrs(), 2'($urandom_range(2)), a);

        // Asynchronous reset between edges with live entries and full credit.
        step(0, 2, ALU, MULT, 8'h00, 2, a);
        step(0, 2, LSU, BTU, 8'h00, 2, a);
        flush = 1'b0; enq_valid = '0; rs_free = 8'hAA; rob_free = 2'd2;
        #1;
        chk("pre_areset_disp", disp_valid, 2'b11);
        #1 reset_n = 1'b0;
        #1;
        chk("areset_disp_valid", disp_valid, 0);
        chk("areset_rs_load", rs_load, 0);
        chk("areset_stall", stall, 0);
        chk("areset_enq_ready", enq_ready, 1);
        chk("areset_occ", occupancy, 0);
        q_pkt.delete();
        q_fu.delete();
        #1 reset_n = 1'b1;
        @(negedge clk);
        step(0, 2, BTU, ALU, 8'hAA, 2, a);
        step(0, 0, LSU, LSU, 8'hAA, 2, a);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised in-order instruction queue that sits between the decoder and the rename/dispatch logic. It buffers up to `DEPTH` decoded packets and accepts up to `ENQ_W` per cycle. It releases up to `DEQ_W` per cycle in program order, gated per functional unit by reservation-station free counts and globally by ROB free slots. It replaces the single-packet, full-flag stall scheme with credit-based multi-issue and adds a misprediction flush.

## Interface
- `DEPTH`, 8: queue entries; power of two, `DEPTH >= max(ENQ_W, DEQ_W)`.
- `ENQ_W`, 2: enqueue slots per cycle.
- `DEQ_W`, 2: dispatch slots per cycle.
- `PKT_W`, 128: opaque decoded-packet width.
- `NUM_FU`, 4: functional-unit classes (LSU, MULT, BTU, ALU order).
- `FU_IDX_W`, 2: FU index width, `2**FU_IDX_W >= NUM_FU`.
- Derived: `CNT_W = $clog2(DEQ_W+1)`, `OCC_W = $clog2(DEPTH+1)`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous queue clear (branch mispredict).
- `enq_valid` in ENQ_W: per-slot valid; must be contiguous from slot 0.
- `enq_pkt` in ENQ_W*PKT_W: packets; slot 0 is oldest.
- `enq_fu` in ENQ_W*FU_IDX_W: target FU per slot; must be < NUM_FU.
- `enq_ready` out 1: queue can take a full ENQ_W group this cycle.
- `rs_free` in NUM_FU*CNT_W: free RS entries per FU, producer-saturated to DEQ_W.
- `rob_free` in CNT_W: free ROB entries, saturated to DEQ_W.
- `disp_valid` out DEQ_W: per-slot dispatch this cycle; contiguous from slot 0.
- `disp_pkt` out DEQ_W*PKT_W: packets at head+k.
- `disp_fu` out DEQ_W*FU_IDX_W: FU of each dispatched slot.
- `rs_load` out NUM_FU: bit f is set if at least one slot dispatches to FU f.
- `stall` out 1: queue is non-empty and no slot dispatches (no flush).
- `occupancy` out OCC_W: registered entry count.

## Operation
- Storage: circular buffer of `{pkt, fu}`, with `head`/`tail` pointers of `$clog2(DEPTH)` bits that wrap modulo DEPTH, plus a registered `occupancy`.
- Candidate slot k (0..DEQ_W-1) is entry `head+k` and exists iff `k < occupancy`.
- Slot k dispatches iff:
  - it exists;
  - slot k-1 dispatched (k=0 exempt);
  - `k < rob_free`;
  - the number of slots j<k already dispatched to the same FU is less than `rs_free[fu_k]`;
  - `flush` is 0.
- Selection is strictly in order: the first blocked slot blocks all younger slots.
- `n_deq` = popcount(disp_valid). `head += n_deq`.
- `enq_ready = (DEPTH - occupancy >= ENQ_W) && !flush`. It is computed from registered occupancy only, so same-cycle dequeues do not raise it.
- Enqueue fires when `enq_ready && enq_valid[0]`. `n_enq` = popcount(enq_valid). Slots are written at `tail..tail+n_enq-1`, then `tail += n_enq`.
- `occupancy_next = occupancy + n_enq - n_deq` (simultaneous enq/deq allowed).
- No enqueue-to-dispatch bypass. An empty queue outputs `disp_valid=0`.
- Flush priority: on `flush`, the next state is head=tail=0 and occupancy=0. Any enqueue in the same cycle is discarded, and all outputs except `occupancy` are masked to 0 that cycle.
- `disp_pkt`/`disp_fu` for non-dispatching slots are don't-care. Verification must check them only where `disp_valid` is set.
- Illegal inputs (non-contiguous `enq_valid`, `enq_fu >= NUM_FU`, enqueue while `!enq_ready`) are caught by assertions and have undefined results.

## Timing
- Reset (`reset_n`=0, asynchronous): head=tail=0, occupancy=0, disp_valid=0, rs_load=0, stall=0, enq_ready=1. The queue contents are not reset.
- Reset release takes effect at the first rising edge with `reset_n`=1.
- Latency: a packet enqueued at edge N is visible on `disp_*` in cycle N+1 at the earliest.
- All `disp_*`, `rs_load` and `stall` are combinational from registered state plus `rs_free`/`rob_free`/`flush`, and are consumed by the RS/ROB on the same edge.
- Full: with `occupancy > DEPTH-ENQ_W`, `enq_ready`=0 even if a dispatch frees entries that cycle.
- Wrap-around: `head+k` and `tail+i` index modulo DEPTH, with no bubble at the boundary.
- Reset asserted mid-operation discards all entries immediately. No partial dispatch is reported after assertion.

## Test plan
- **Basic flow.** After reset, enqueue A(ALU),B(MULT) with rs_free all 2 and rob_free=2.
  - Cycle 1: disp_valid=2'b11, rs_load=4'b1010 (bit 3 ALU, bit 1 MULT), occupancy 2→0.
- **Per-FU credit.** Queue holds ALU,ALU with rs_free[ALU]=1.
  - Only slot 0 dispatches. Next cycle the second ALU is at slot 0.
  - With rs_free[ALU]=0, stall=1 and occupancy stays 2.
- **In-order blocking and ROB limit.**
  - Queue holds MULT,ALU with rs_free[MULT]=0: disp_valid=0 and stall=1 despite the free ALU.
  - With rob_free=1: only slot 0 dispatches.
- **Full and wrap.** DEPTH=8.
  - Fill with 4 enqueue pairs and rs_free=0: occupancy=8, enq_ready=0.
  - Release credits and stream 20 packets: output order matches input order across the pointer wrap, with no loss or duplicates.
- **Simultaneous enq/deq.** With occupancy=4, enqueue 2 and dispatch 2 on the same edge → occupancy=4, with correct FIFO order.
- **Flush and async reset.**
  - `flush` with occupancy=5 plus a concurrent enqueue: disp_valid=0 that cycle and occupancy=0 next cycle.
  - Drop `reset_n` between edges mid-stream: outputs go to reset values before the next edge.
